// File: rtl/clock_mode_ctrl.sv
// Mode controller for a mm:ss clock: run/pause/adjust FSM, increment pulse
// generation from divider ticks, and digit blanking while adjusting.
module clock_mode_ctrl #(
    parameter bit BLINK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_4hz,
    input  logic       pause_btn,
    input  logic       adjust,
    input  logic       select,
    input  logic       sec_max,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       blank_sec,
    output logic       blank_min,
    output logic [1:0] mode,
    output logic       running
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        PAUSE   = 2'b01,
        ADJ_MIN = 2'b10,
        ADJ_SEC = 2'b11
    } state_t;

    state_t state, state_next;
    logic   run_flag, run_next;
    logic   blink_phase, blink_next;
    logic   tick_1hz_p0, tick_2hz_p0, tick_4hz_p0, pause_btn_p0;
    logic   ev_1hz, ev_2hz, ev_4hz, ev_pause;
    logic   sec_inc_next, min_inc_next;
    logic   sec_inc_p1, min_inc_p1;

    // Stage 0: edge detection against the previous-value flops
    assign ev_1hz   = tick_1hz  & ~tick_1hz_p0;
    assign ev_2hz   = tick_2hz  & ~tick_2hz_p0;
    assign ev_4hz   = tick_4hz  & ~tick_4hz_p0;
    assign ev_pause = pause_btn & ~pause_btn_p0;

    always_comb begin
        run_next     = run_flag ^ ev_pause;
        state_next   = run_next ? RUN : PAUSE;
        sec_inc_next = 1'b0;
        min_inc_next = 1'b0;
        blink_next   = 1'b0;

        if (adjust)
            state_next = select ? ADJ_MIN : ADJ_SEC;

        // Increments follow the state held now, not the one being entered
        case (state)
            RUN: begin
                sec_inc_next = ev_1hz;
                min_inc_next = ev_1hz & sec_max;
            end
            ADJ_SEC: sec_inc_next = ev_2hz;
            ADJ_MIN: min_inc_next = ev_2hz;
            default: ;
        endcase

        // Phase restarts on any entry into (or swap between) adjust states
        if (state_next[1] && state_next == state)
            blink_next = blink_phase ^ ev_4hz;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            run_flag     <= 1'b1;
            blink_phase  <= 1'b0;
            tick_1hz_p0  <= 1'b0;
            tick_2hz_p0  <= 1'b0;
            tick_4hz_p0  <= 1'b0;
            pause_btn_p0 <= 1'b1;
            sec_inc_p1   <= 1'b0;
            min_inc_p1   <= 1'b0;
        end else begin
            state        <= state_next;
            run_flag     <= run_next;
            blink_phase  <= blink_next;
            tick_1hz_p0  <= tick_1hz;
            tick_2hz_p0  <= tick_2hz;
            tick_4hz_p0  <= tick_4hz;
            pause_btn_p0 <= pause_btn;
            sec_inc_p1   <= sec_inc_next;
            min_inc_p1   <= min_inc_next;
        end
    end

    // Stage 1: registered pulses and state-derived outputs
    assign sec_inc   = sec_inc_p1;
    assign min_inc   = min_inc_p1;
    assign mode      = state;
    assign running   = run_flag;
    assign blank_min = BLINK_EN & blink_phase & (state == ADJ_MIN);
    assign blank_sec = BLINK_EN & blink_phase & (state == ADJ_SEC);

endmodule
